dsp_mac_ctrl: RTL and testbench

DSP_MAC_CTRL -- requirements
Module: dsp_mac_ctrl

---
 rtl/dsp_mac_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_dsp_mac_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dsp_mac_ctrl
// Brief   : Dot-product controller for a pipelined DSP slice; optional job
//           counter enabled by macro DSP_MAC_CTRL_CNT_EN.
// Revision: 1.0
// ============================================================================
module dsp_mac_ctrl #(
  parameter int LAT     = 4,
  parameter int OPM_DLY = 1,
  parameter int LEN_W   = 8
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic [17:0]       a_data,
  input  logic [17:0]       b_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [17:0]       dsp_A,
  output logic [17:0]       dsp_B,
  output logic [7:0]        dsp_OPMODE,
  output logic              dsp_CE,
  input  logic [47:0]       dsp_P,
`ifdef DSP_MAC_CTRL_CNT_EN
  output logic [15:0]       job_cnt,
`endif
  output logic [47:0]       res_data,
  output logic              res_valid,
  input  logic              res_ready
);

  localparam logic [7:0] c_OPM_FIRST  = 8'b0000_0001;
  localparam logic [7:0] c_OPM_ACC    = 8'b0000_1001;
  localparam logic [7:0] c_OPM_BUBBLE = 8'b0000_1000;
  localparam logic [3:0] c_DRAIN_INIT = 4'(LAT - 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DRAIN  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_remain;
  logic [3:0]       r_drain;
  logic             r_first;
  logic [47:0]      r_res;
  logic             w_accept;
  logic             w_last;
  logic             w_res_hs;
  logic [7:0]       w_opm_in;

  assign w_accept = (r_state == S_ISSUE) && in_valid;
  assign w_last   = w_accept && (r_remain == LEN_W'(1));
  assign w_res_hs = (r_state == S_RESULT) && res_ready;
  assign res_data = r_res;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    in_ready    = 1'b0;
    res_valid   = 1'b0;
    dsp_CE      = 1'b0;
    dsp_A       = '0;
    dsp_B       = '0;
    w_opm_in    = 8'h00;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = (len != '0) ? S_ISSUE : S_RESULT;
        end
      end
      S_ISSUE: begin
        in_ready = 1'b1;
        dsp_A    = a_data;
        dsp_B    = b_data;
        dsp_CE   = in_valid;
        w_opm_in = r_first ? c_OPM_FIRST : c_OPM_ACC;
        if (w_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        dsp_CE   = 1'b1;
        w_opm_in = c_OPM_BUBBLE;
        if (r_drain == 4'd0) begin
          w_state_nxt = S_RESULT;
        end
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_remain <= '0;
      r_drain  <= '0;
      r_first  <= 1'b0;
      r_res    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_remain <= len;
            r_first  <= 1'b1;
            if (len == '0) begin
              r_res <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            r_remain <= r_remain - LEN_W'(1);
            r_first  <= 1'b0;
            if (w_last) begin
              r_drain <= c_DRAIN_INIT;
            end
          end
        end
        S_DRAIN: begin
          // Final drain edge: the last product has just settled at dsp_P.
          if (r_drain != 4'd0) begin
            r_drain <= r_drain - 4'd1;
          end else begin
            r_res <= dsp_P;
          end
        end
        default: ;
      endcase
    end
  end

  // OPMODE delay line advances only with the slice clock enable.
  generate
    if (OPM_DLY == 0) begin : g_opm_comb
      assign dsp_OPMODE = w_opm_in;
    end else begin : g_opm_dly
      logic [7:0] r_opm_line [OPM_DLY];
      always_ff @(posedge CLK) begin
        if (!RSTN || w_res_hs) begin
          for (int i = 0; i < OPM_DLY; i++) begin
            r_opm_line[i] <= 8'h00;
          end
        end else if (dsp_CE) begin
          r_opm_line[0] <= w_opm_in;
          for (int i = 1; i < OPM_DLY; i++) begin
            r_opm_line[i] <= r_opm_line[i-1];
          end
        end
      end
      assign dsp_OPMODE = r_opm_line[OPM_DLY-1];
    end
  endgenerate

`ifdef DSP_MAC_CTRL_CNT_EN
  logic [15:0] r_job_cnt;
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_job_cnt <= '0;
    end else if (w_res_hs) begin
      r_job_cnt <= r_job_cnt + 16'd1;
    end
  end
  assign job_cnt = r_job_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dsp_mac_ctrl
// Brief   : Directed bench for dsp_mac_ctrl with a behavioural DSP slice
//           (LAT = 4, OPM_DLY = 1). Revision: 1.0
// ============================================================================
module tb_dsp_mac_ctrl;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        busy;
  logic [17:0] a_data = '0;
  logic [17:0] b_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] dsp_A;
  logic [17:0] dsp_B;
  logic [7:0]  dsp_OPMODE;
  logic        dsp_CE;
  logic [47:0] dsp_P;
  logic [47:0] res_data;
  logic        res_valid;
  logic        res_ready = 1'b0;
`ifdef DSP_MAC_CTRL_CNT_EN
  logic [15:0] job_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int ce_cnt = 0;

  always #5 CLK = ~CLK;

  dsp_mac_ctrl #(.LAT(4), .OPM_DLY(1), .LEN_W(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .start(start), .len(len), .busy(busy),
    .a_data(a_data), .b_data(b_data), .in_valid(in_valid), .in_ready(in_ready),
    .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_OPMODE(dsp_OPMODE), .dsp_CE(dsp_CE),
    .dsp_P(dsp_P),
`ifdef DSP_MAC_CTRL_CNT_EN
    .job_cnt(job_cnt),
`endif
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
  );

  // Slice model: A/B reg, M reg (OPMODE reg alongside), P reg; never reset.
  logic [17:0] s_a = '0;
  logic [17:0] s_b = '0;
  logic [47:0] s_m = '0;
  logic [7:0]  s_opm = '0;
  logic [47:0] s_p = '0;
  always @(posedge CLK) begin
    if (dsp_CE) begin
      s_a   <= dsp_A;
      s_b   <= dsp_B;
      s_m   <= 48'(s_a) * 48'(s_b);
      s_opm <= dsp_OPMODE;
      case (s_opm)
        8'h01:   s_p <= s_m;
        8'h09:   s_p <= s_p + s_m;
        8'h08:   s_p <= s_p;
        default: s_p <= '0;
      endcase
      ce_cnt <= ce_cnt + 1;
    end
  end
  assign dsp_P = s_p;

  task automatic do_start(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic do_pair(input logic [17:0] a, input logic [17:0] b);
    a_data   = a;
    b_data   = b;
    in_valid = 1'b1;
    @(negedge CLK);
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic finish_res;
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    a_data = 18'h155;
    b_data = 18'h0AA;
    RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%0b exp=0", res_valid); end
    checks++; if (res_data !== 48'd0) begin failures++; $display("FAIL reset_res_data got=%0d exp=0", res_data); end
    checks++; if (dsp_CE !== 1'b0) begin failures++; $display("FAIL reset_dsp_CE got=%0b exp=0", dsp_CE); end
    checks++; if (dsp_A !== 18'd0 || dsp_B !== 18'd0) begin failures++; $display("FAIL reset_dsp_AB got=%0h/%0h exp=0/0", dsp_A, dsp_B); end
    checks++; if (dsp_OPMODE !== 8'h00) begin failures++; $display("FAIL reset_opmode got=%0h exp=00", dsp_OPMODE); end
  endtask

  task automatic test_basic;
    logic exp_v;
    do_start(8'd3);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL basic_issue busy=%0b in_ready=%0b exp=1/1", busy, in_ready); end
    do_pair(18'd2, 18'd3);
    checks++; if (dsp_OPMODE !== 8'h01) begin failures++; $display("FAIL basic_opm_first got=%0h exp=01", dsp_OPMODE); end
    do_pair(18'd4, 18'd5);
    checks++; if (dsp_OPMODE !== 8'h09) begin failures++; $display("FAIL basic_opm_acc got=%0h exp=09", dsp_OPMODE); end
    do_pair(18'd6, 18'd7);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || dsp_CE !== 1'b1 || dsp_A !== 18'd0 || dsp_B !== 18'd0) begin
      failures++; $display("FAIL basic_drain in_ready=%0b ce=%0b A=%0d B=%0d exp=0/1/0/0", in_ready, dsp_CE, dsp_A, dsp_B);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLK);
      exp_v = (i == 3);
      checks++; if (res_valid !== exp_v) begin failures++; $display("FAIL basic_res_valid_t%0d got=%0b exp=%0b", i, res_valid, exp_v); end
      if (i == 1) begin
        checks++; if (dsp_OPMODE !== 8'h08) begin failures++; $display("FAIL basic_opm_bubble got=%0h exp=08", dsp_OPMODE); end
      end
    end
    checks++; if (res_data !== 48'd68) begin failures++; $display("FAIL basic_res_data got=%0d exp=68", res_data); end
    finish_res;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL basic_idle busy=%0b res_valid=%0b exp=0/0", busy, res_valid); end
    checks++; if (dsp_OPMODE !== 8'h00) begin failures++; $display("FAIL basic_idle_opm got=%0h exp=00", dsp_OPMODE); end
  endtask

  task automatic test_stall;
    bit ok;
    int c0;
    do_start(8'd3);
    c0 = ce_cnt;
    do_pair(18'd2, 18'd3);
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (dsp_CE !== 1'b0) begin failures++; $display("FAIL stall_ce_c%0d got=%0b exp=0", i, dsp_CE); end
      checks++; if (dsp_OPMODE !== 8'h01) begin failures++; $display("FAIL stall_opm_c%0d got=%0h exp=01", i, dsp_OPMODE); end
      @(negedge CLK);
    end
    do_pair(18'd4, 18'd5);
    do_pair(18'd6, 18'd7);
    in_valid = 1'b0;
    wait_res(ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout got=no_result exp=result"); end
    checks++; if (res_data !== 48'd68) begin failures++; $display("FAIL stall_res_data got=%0d exp=68", res_data); end
    checks++; if (ce_cnt - c0 != 6) begin failures++; $display("FAIL stall_ce_edges got=%0d exp=6", ce_cnt - c0); end
    finish_res;
  endtask

  task automatic test_len0;
    int c0;
    c0 = ce_cnt;
    do_start(8'd0);
    checks++; if (res_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL len0_result res_valid=%0b busy=%0b exp=1/1", res_valid, busy); end
    checks++; if (res_data !== 48'd0) begin failures++; $display("FAIL len0_res_data got=%0d exp=0", res_data); end
    finish_res;
    checks++; if (ce_cnt != c0) begin failures++; $display("FAIL len0_ce_edges got=%0d exp=0", ce_cnt - c0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL len0_idle busy=%0b exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    res_ready = 1'b1;
    do_start(8'd1);
    do_pair(18'd5, 18'd5);
    in_valid = 1'b0;
    wait_res(ok);
    checks++; if (!ok || res_data !== 48'd25) begin failures++; $display("FAIL b2b_first got=%0d ok=%0b exp=25", res_data, ok); end
    @(negedge CLK);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle busy=%0b exp=0", busy); end
    do_start(8'd1);
    do_pair(18'd1, 18'd1);
    in_valid = 1'b0;
    wait_res(ok);
    checks++; if (!ok || res_data !== 48'd1) begin failures++; $display("FAIL b2b_second got=%0d ok=%0b exp=1", res_data, ok); end
    @(negedge CLK);
    res_ready = 1'b0;
  endtask

  task automatic test_reset_midjob;
    bit ok;
    int seen;
    do_start(8'd4);
    do_pair(18'd1, 18'd2);
    do_pair(18'd3, 18'd4);
    in_valid = 1'b0;
    RSTN = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || res_valid !== 1'b0 || dsp_CE !== 1'b0) begin
      failures++; $display("FAIL midrst_ctrl busy=%0b in_ready=%0b res_valid=%0b ce=%0b exp=0/0/0/0", busy, in_ready, res_valid, dsp_CE);
    end
    checks++; if (res_data !== 48'd0 || dsp_A !== 18'd0 || dsp_B !== 18'd0 || dsp_OPMODE !== 8'h00) begin
      failures++; $display("FAIL midrst_data res=%0d A=%0d B=%0d opm=%0h exp=0/0/0/00", res_data, dsp_A, dsp_B, dsp_OPMODE);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (res_valid) seen++;
      @(negedge CLK);
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midrst_no_result got=%0d exp=0", seen); end
    do_start(8'd1);
    do_pair(18'd3, 18'd3);
    in_valid = 1'b0;
    wait_res(ok);
    checks++; if (!ok || res_data !== 48'd9) begin failures++; $display("FAIL midrst_next got=%0d ok=%0b exp=9", res_data, ok); end
    finish_res;
  endtask

  task automatic test_hold;
    bit ok;
`ifdef DSP_MAC_CTRL_CNT_EN
    RSTN = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      do_start(8'd1);
      do_pair(18'(j), 18'd2);
      in_valid = 1'b0;
      wait_res(ok);
      finish_res;
    end
    checks++; if (job_cnt !== 16'd3) begin failures++; $display("FAIL cnt_three got=%0d exp=3", job_cnt); end
`endif
    do_start(8'd1);
    do_pair(18'd7, 18'd11);
    in_valid = 1'b0;
    wait_res(ok);
    checks++; if (!ok) begin failures++; $display("FAIL hold_timeout got=no_result exp=result"); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (res_valid !== 1'b1 || res_data !== 48'd77) begin failures++; $display("FAIL hold_c%0d res_valid=%0b res=%0d exp=1/77", i, res_valid, res_data); end
`ifdef DSP_MAC_CTRL_CNT_EN
      checks++; if (job_cnt !== 16'd3) begin failures++; $display("FAIL hold_cnt_c%0d got=%0d exp=3", i, job_cnt); end
`endif
      @(negedge CLK);
    end
    finish_res;
`ifdef DSP_MAC_CTRL_CNT_EN
    checks++; if (job_cnt !== 16'd4) begin failures++; $display("FAIL cnt_four got=%0d exp=4", job_cnt); end
`endif
  endtask

  initial begin
    @(negedge CLK);
    test_reset;
    test_basic;
    test_stall;
    test_len0;
    test_back_to_back;
    test_reset_midjob;
    test_hold;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
